xbar_allocator: RTL and testbench
=================================

# xbar_allocator

- Parametrised crossbar allocator that turns per-input routing decisions into registered select codes for the per-output data selectors.
- Generalises the fixed 3-port x/y/local transport stage to NUM_PORTS ports.
- Adds round-robin arbitration on output conflicts and packet-length locking, so a multi-flit packet holds its output until its last flit passes.
- Adds per-input fault masking and a stall/bubble mode.

## Interface
Parameters:
- NUM_PORTS, 3, number of input ports and output ports (codes 1=x, 2=y, 3=local when 3).
- LEN_W, 4, width of the packet-length field, in flits.
- SEL_W (localparam), $clog2(NUM_PORTS+1), width of one select/destination code.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1, sampled on posedge clk).
- route_req_valid  in  NUM_PORTS  input i has a head flit waiting for allocation.
- route_dest  in  NUM_PORTS*SEL_W  destination of input i. Code o+1 selects output o; code 0 or any code above NUM_PORTS is invalid.
- route_len  in  NUM_PORTS*LEN_W  packet length of input i in flits; 0 is treated as 1.
- flit_fire  in  NUM_PORTS  one flit of input i crossed the crossbar this cycle.
- fail  in  NUM_PORTS  input i is faulty.
- stall  in  1  bubble request.
- control  out  NUM_PORTS*SEL_W  select code for output o: owner input index+1, or 0 for none.
- grant  out  NUM_PORTS  one-cycle pulse: input i was allocated.
- busy  out  NUM_PORTS  output o is locked.
- err_dest  out  NUM_PORTS  one-cycle pulse: input i requested with an invalid destination.

## Operation
Per-output state machine, two states: IDLE and LOCKED.
- Each output also holds `owner` (input index), `rem` (remaining flits, LEN_W bits) and `ptr` (round-robin pointer).

Request eligibility. Input i is eligible for output o when all of these hold:
- route_req_valid[i] = 1.
- fail[i] = 0.
- dest_i = o+1.
- Input i owns no output.

Invalid destination:
- A valid request with an invalid dest pulses err_dest[i] for one cycle.
- That request is never granted.

IDLE → LOCKED (only when stall = 0):
- Winner = first eligible input found scanning ptr, ptr+1, …, wrapping modulo NUM_PORTS.
- owner ← winner.
- rem ← route_len (0 loads 1).
- ptr ← (winner+1) mod NUM_PORTS.
- grant[winner] pulses.
- busy[o] ← 1.

LOCKED behaviour:
- flit_fire[owner] with rem > 1 decrements rem.
- flit_fire[owner] with rem = 1 → IDLE.
- fail[owner] = 1 → IDLE (packet aborted, regardless of rem).
- flit_fire on any input that owns nothing is ignored.

Output registers:
- control[o] ← 0 when stall = 1 or o is IDLE; otherwise owner+1.

Stall:
- No new grants while stall = 1.
- rem is not decremented; flit_fire is ignored.
- Lock state, owner and ptr are retained.
- control is restored on the first edge after stall falls.

Release:
- A released output is not re-granted on the same edge.
- Earliest re-grant is the following edge.

Simultaneous events:
- Last flit_fire and fail on the same edge: single release, no error.
- Inputs are never granted to two outputs, because each input has a single destination.

## Timing
- Request present before edge N → grant, control and busy visible from edge N to edge N+1. Allocation latency is 1 cycle.
- grant is asserted for exactly 1 cycle.
- route_req_valid must be held until grant is seen; a request dropped earlier is simply not granted.
- Final flit_fire at edge M → control = 0 and busy = 0 after edge M. Next grant to that output at edge M+1 at the earliest.
- stall asserted at edge S → control = 0 after S. stall deasserted at edge T → owner codes return after T.
- Reset (rst_n = 1 at an edge), regardless of state:
  - control = 0, grant = 0, busy = 0, err_dest = 0.
  - All outputs IDLE; rem = 0; ptr = 0.
- Reset during a LOCKED packet discards the lock with no error pulse.

## Test plan
- Conflict round-robin (NUM_PORTS = 3):
  - Stimulus: inputs 0 and 1 both request dest 2, len 1; fire each granted flit.
  - Response: input 0 granted first (control[1] = 1), then input 1 two edges later (control[1] = 2). With repeated requests the winner alternates 0, 1, 0.
- Packet lock:
  - Stimulus: input 2 requests dest 3, len 4; input 0 requests dest 3 meanwhile.
  - Response: control[2] = 3 for 4 flit_fire[2] pulses; input 0 is granted on the edge after the 4th fire.
- Fault abort:
  - Stimulus: input 1 locked to output 0 with len 8; raise fail[1] after 2 fires.
  - Response: control[0] = 0 and busy[0] = 0 on the next edge; input 1 is not re-granted while fail[1] = 1.
- Stall bubble:
  - Stimulus: outputs locked to inputs 0, 1, 2; stall = 1 for 3 cycles with flit_fire held high.
  - Response: all control = 0 during the stall; rem values unchanged; codes 1, 2, 3 return one edge after stall falls.
- Invalid destination and zero length:
  - Stimulus: input 0 requests dest 0, then dest 2 with len 0.
  - Response: err_dest[0] pulses and there is no grant for the first request; the second is granted and releases after one fire.
- Mid-packet reset:
  - Stimulus: assert rst_n for one edge while busy = 3'b111.
  - Response: all outputs 0; the next request to output 0 wins through ptr = 0, lowest eligible input first.

Source files
------------

// File: rtl/xbar_allocator.sv
`default_nettype none
// ============================================================================
// Module   : xbar_allocator
// Purpose  : Crossbar allocator. Converts per-input routing requests into
//            registered select codes for the per-output data selectors, with
//            round-robin conflict arbitration, packet-length locking,
//            per-input fault masking and a stall/bubble mode.
// Ports    : clk             - clock
//            rst_n           - synchronous reset, active-high
//            route_req_valid - per-input head flit waiting for allocation
//            route_dest      - per-input destination code (o+1 = output o)
//            route_len       - per-input packet length in flits (0 means 1)
//            flit_fire       - per-input flit crossed the crossbar
//            fail            - per-input fault indication
//            stall           - bubble request
//            control         - per-output select code (owner+1, 0 = none)
//            grant           - per-input one-cycle allocation pulse
//            busy            - per-output lock indication
//            err_dest        - per-input one-cycle invalid-destination pulse
// Revision : 1.0 - initial release
// ============================================================================
module xbar_allocator #(
    parameter int NUM_PORTS = 3,
    parameter int LEN_W     = 4,
    localparam int SEL_W    = $clog2(NUM_PORTS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         route_req_valid,
    input  logic [NUM_PORTS*SEL_W-1:0]   route_dest,
    input  logic [NUM_PORTS*LEN_W-1:0]   route_len,
    input  logic [NUM_PORTS-1:0]         flit_fire,
    input  logic [NUM_PORTS-1:0]         fail,
    input  logic                         stall,
    output logic [NUM_PORTS*SEL_W-1:0]   control,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [NUM_PORTS-1:0]         busy,
    output logic [NUM_PORTS-1:0]         err_dest
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [NUM_PORTS-1:0]           w_locked;
    logic [NUM_PORTS*SEL_W-1:0]     w_owner_flat;
    logic [NUM_PORTS*NUM_PORTS-1:0] w_gnt_flat;
    logic [NUM_PORTS-1:0]           w_owns;
    logic [NUM_PORTS-1:0]           w_grant_any;
    logic [NUM_PORTS-1:0]           w_err;
    logic [NUM_PORTS-1:0]           r_grant;
    logic [NUM_PORTS-1:0]           r_err_dest;

    // An input that already holds an output may not compete for another one.
    always_comb begin
        w_owns = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_locked[o] && (w_owner_flat[o*SEL_W +: SEL_W] == SEL_W'(i))) begin
                    w_owns[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_err = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_err[i] = route_req_valid[i] &&
                       ((route_dest[i*SEL_W +: SEL_W] == '0) ||
                        (route_dest[i*SEL_W +: SEL_W] > SEL_W'(NUM_PORTS)));
        end
    end

    // Each input has one destination, so at most one output grants it;
    // OR-ing the per-output grant vectors is therefore collision free.
    always_comb begin
        w_grant_any = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_grant_any = w_grant_any | w_gnt_flat[o*NUM_PORTS +: NUM_PORTS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_grant    <= '0;
            r_err_dest <= '0;
        end else begin
            r_grant    <= w_grant_any;
            r_err_dest <= w_err;
        end
    end

    assign grant    = r_grant;
    assign err_dest = r_err_dest;
    assign busy     = w_locked;

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            logic [0:0]           r_state;
            logic [0:0]           w_state_nxt;
            logic [SEL_W-1:0]     r_owner;
            logic [SEL_W-1:0]     w_owner_nxt;
            logic [SEL_W-1:0]     r_ptr;
            logic [SEL_W-1:0]     w_ptr_nxt;
            logic [SEL_W-1:0]     r_control;
            logic [SEL_W-1:0]     w_control_nxt;
            logic [LEN_W-1:0]     r_rem;
            logic [LEN_W-1:0]     w_rem_nxt;
            logic [NUM_PORTS-1:0] w_elig;
            logic [NUM_PORTS-1:0] w_cand;
            logic [NUM_PORTS-1:0] w_gnt;
            logic                 w_found;
            logic [SEL_W-1:0]     w_cand_idx;
            logic [SEL_W-1:0]     w_cand_ptr;
            logic [LEN_W-1:0]     w_cand_len;
            logic                 w_owner_fail;
            logic                 w_owner_fire;

            always_comb begin
                w_elig = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    w_elig[i] = route_req_valid[i] && !fail[i] && !w_owns[i] &&
                                (route_dest[i*SEL_W +: SEL_W] == SEL_W'(o + 1));
                end
            end

            // Round-robin scan starting at the pointer, wrapping.
            always_comb begin
                w_found    = 1'b0;
                w_cand     = '0;
                w_cand_idx = '0;
                w_cand_ptr = '0;
                w_cand_len = '0;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (!w_found && w_elig[i] &&
                            (((int'(r_ptr) + k) % NUM_PORTS) == i)) begin
                            w_found    = 1'b1;
                            w_cand[i]  = 1'b1;
                            w_cand_idx = SEL_W'(i);
                            w_cand_ptr = (i + 1 == NUM_PORTS) ? '0 : SEL_W'(i + 1);
                            w_cand_len = route_len[i*LEN_W +: LEN_W];
                        end
                    end
                end
            end

            always_comb begin
                w_owner_fail = 1'b0;
                w_owner_fire = 1'b0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (r_owner == SEL_W'(i)) begin
                        w_owner_fail = fail[i];
                        w_owner_fire = flit_fire[i];
                    end
                end
            end

            // Next-state logic. Stall freezes everything except the visible
            // select code, which is forced to zero to create the bubble.
            always_comb begin
                w_state_nxt = r_state;
                w_owner_nxt = r_owner;
                w_ptr_nxt   = r_ptr;
                w_rem_nxt   = r_rem;
                w_gnt       = '0;
                case (r_state)
                    c_IDLE: begin
                        if (!stall && w_found) begin
                            w_state_nxt = c_LOCKED;
                            w_owner_nxt = w_cand_idx;
                            w_ptr_nxt   = w_cand_ptr;
                            w_rem_nxt   = (w_cand_len == '0) ? LEN_W'(1) : w_cand_len;
                            w_gnt       = w_cand;
                        end
                    end
                    c_LOCKED: begin
                        if (!stall) begin
                            // Fault abort wins over a coincident last flit;
                            // both end in one plain release.
                            if (w_owner_fail) begin
                                w_state_nxt = c_IDLE;
                                w_rem_nxt   = '0;
                            end else if (w_owner_fire) begin
                                if (r_rem > LEN_W'(1)) begin
                                    w_rem_nxt = r_rem - LEN_W'(1);
                                end else begin
                                    w_state_nxt = c_IDLE;
                                    w_rem_nxt   = '0;
                                end
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = c_IDLE;
                    end
                endcase
                w_control_nxt = (stall || (w_state_nxt == c_IDLE)) ? '0
                                                                   : w_owner_nxt + SEL_W'(1);
            end

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_state   <= c_IDLE;
                    r_owner   <= '0;
                    r_ptr     <= '0;
                    r_rem     <= '0;
                    r_control <= '0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_owner   <= w_owner_nxt;
                    r_ptr     <= w_ptr_nxt;
                    r_rem     <= w_rem_nxt;
                    r_control <= w_control_nxt;
                end
            end

            assign w_locked[o]                              = (r_state == c_LOCKED);
            assign w_owner_flat[o*SEL_W +: SEL_W]           = r_owner;
            assign w_gnt_flat[o*NUM_PORTS +: NUM_PORTS]     = w_gnt;
            assign control[o*SEL_W +: SEL_W]                = r_control;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_xbar_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_allocator
// Purpose  : Directed self-checking bench for xbar_allocator (3 ports).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_allocator;

    localparam int c_N     = 3;
    localparam int c_LEN_W = 4;
    localparam int c_SEL_W = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [c_N-1:0]           route_req_valid;
    logic [c_N*c_SEL_W-1:0]   route_dest;
    logic [c_N*c_LEN_W-1:0]   route_len;
    logic [c_N-1:0]           flit_fire;
    logic [c_N-1:0]           fail;
    logic                     stall;
    logic [c_N*c_SEL_W-1:0]   control;
    logic [c_N-1:0]           grant;
    logic [c_N-1:0]           busy;
    logic [c_N-1:0]           err_dest;

    int r_checks = 0;
    int r_errors = 0;

    xbar_allocator #(
        .NUM_PORTS (c_N),
        .LEN_W     (c_LEN_W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .route_req_valid (route_req_valid),
        .route_dest      (route_dest),
        .route_len       (route_len),
        .flit_fire       (flit_fire),
        .fail            (fail),
        .stall           (stall),
        .control         (control),
        .grant           (grant),
        .busy            (busy),
        .err_dest        (err_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] dest, input logic [3:0] len);
        route_dest[i*c_SEL_W +: c_SEL_W] = dest;
        route_len[i*c_LEN_W +: c_LEN_W]  = len;
    endtask

    initial begin
        rst_n           = 1'b1;
        route_req_valid = '0;
        route_dest      = '0;
        route_len       = '0;
        flit_fire       = '0;
        fail            = '0;
        stall           = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_control", 32'(control), 32'h0);
        check("rst_grant",   32'(grant),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_err",     32'(err_dest), 32'h0);
        rst_n = 1'b0;
        tick();

        // Conflict round-robin: inputs 0 and 1 to output 1
        set_req(0, 2'd2, 4'd1);
        set_req(1, 2'd2, 4'd1);
        route_req_valid = 3'b011;
        tick();
        check("rr1_grant",   32'(grant),   32'h1);
        check("rr1_control", 32'(control), 32'({2'd0, 2'd1, 2'd0}));
        check("rr1_busy",    32'(busy),    32'h2);
        route_req_valid = 3'b010;
        flit_fire       = 3'b001;
        tick();
        check("rr1_release", 32'(control), 32'h0);
        check("rr1_rel_grant", 32'(grant), 32'h0);
        flit_fire = 3'b000;
        tick();
        check("rr2_grant",   32'(grant),   32'h2);
        check("rr2_control", 32'(control), 32'({2'd0, 2'd2, 2'd0}));
        route_req_valid = 3'b011;
        flit_fire       = 3'b010;
        tick();
        check("rr2_release", 32'(busy), 32'h0);
        flit_fire = 3'b000;
        tick();
        check("rr3_grant",   32'(grant),   32'h1);
        check("rr3_control", 32'(control), 32'({2'd0, 2'd1, 2'd0}));
        route_req_valid = 3'b000;
        flit_fire       = 3'b001;
        tick();
        check("rr3_release", 32'(busy), 32'h0);
        flit_fire = 3'b000;

        // Packet lock: input 2 len 4 on output 2, input 0 waits
        set_req(2, 2'd3, 4'd4);
        route_req_valid = 3'b100;
        tick();
        check("lk_grant",   32'(grant),   32'h4);
        check("lk_control", 32'(control), 32'({2'd3, 2'd0, 2'd0}));
        set_req(0, 2'd3, 4'd1);
        route_req_valid = 3'b001;
        flit_fire       = 3'b100;
        for (int f = 1; f <= 3; f++) begin
            tick();
            check("lk_hold_control", 32'(control), 32'({2'd3, 2'd0, 2'd0}));
            check("lk_hold_grant",   32'(grant),   32'h0);
        end
        tick();
        check("lk_release", 32'(control), 32'h0);
        check("lk_rel_busy", 32'(busy), 32'h0);
        flit_fire = 3'b000;
        tick();
        check("lk_next_grant",   32'(grant),   32'h1);
        check("lk_next_control", 32'(control), 32'({2'd1, 2'd0, 2'd0}));
        route_req_valid = 3'b000;
        flit_fire       = 3'b001;
        tick();
        flit_fire = 3'b000;

        // Fault abort: input 1 len 8 on output 0
        set_req(1, 2'd1, 4'd8);
        route_req_valid = 3'b010;
        tick();
        check("ft_grant",   32'(grant),   32'h2);
        check("ft_control", 32'(control), 32'({2'd0, 2'd0, 2'd2}));
        route_req_valid = 3'b000;
        flit_fire       = 3'b010;
        tick(); tick();
        check("ft_locked", 32'(busy), 32'h1);
        flit_fire       = 3'b000;
        fail            = 3'b010;
        route_req_valid = 3'b010;
        tick();
        check("ft_abort_control", 32'(control), 32'h0);
        check("ft_abort_busy",    32'(busy),    32'h0);
        tick(); tick();
        check("ft_no_regrant", 32'(grant), 32'h0);
        check("ft_still_idle", 32'(busy),  32'h0);
        fail            = 3'b000;
        route_req_valid = 3'b000;
        tick();

        // Stall bubble: inputs 0,1,2 to outputs 0,1,2, len 5
        set_req(0, 2'd1, 4'd5);
        set_req(1, 2'd2, 4'd5);
        set_req(2, 2'd3, 4'd5);
        route_req_valid = 3'b111;
        tick();
        check("st_grant",   32'(grant),   32'h7);
        check("st_control", 32'(control), 32'({2'd3, 2'd2, 2'd1}));
        route_req_valid = 3'b000;
        stall           = 1'b1;
        flit_fire       = 3'b111;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("st_bubble", 32'(control), 32'h0);
            check("st_busy",   32'(busy),    32'h7);
        end
        stall     = 1'b0;
        flit_fire = 3'b000;
        tick();
        check("st_restore", 32'(control), 32'({2'd3, 2'd2, 2'd1}));
        // rem must still be 5: three fires leave every output locked
        flit_fire = 3'b111;
        tick(); tick(); tick();
        flit_fire = 3'b000;
        check("st_rem_kept", 32'(busy), 32'h7);

        // Mid-packet reset, then pointer back at zero for output 0
        rst_n = 1'b1;
        tick();
        check("mr_control", 32'(control), 32'h0);
        check("mr_busy",    32'(busy),    32'h0);
        check("mr_err",     32'(err_dest), 32'h0);
        rst_n = 1'b0;
        set_req(0, 2'd1, 4'd1);
        set_req(2, 2'd1, 4'd1);
        route_req_valid = 3'b101;
        tick();
        check("mr_ptr_grant",   32'(grant),   32'h1);
        check("mr_ptr_control", 32'(control), 32'({2'd0, 2'd0, 2'd1}));
        route_req_valid = 3'b000;
        flit_fire       = 3'b001;
        tick();
        flit_fire = 3'b000;

        // Invalid destination, then zero length
        set_req(0, 2'd0, 4'd1);
        route_req_valid = 3'b001;
        tick();
        check("inv_err",   32'(err_dest), 32'h1);
        check("inv_grant", 32'(grant),    32'h0);
        check("inv_busy",  32'(busy),     32'h0);
        set_req(0, 2'd2, 4'd0);
        tick();
        check("zl_err",     32'(err_dest), 32'h0);
        check("zl_grant",   32'(grant),    32'h1);
        check("zl_control", 32'(control),  32'({2'd0, 2'd1, 2'd0}));
        route_req_valid = 3'b000;
        flit_fire       = 3'b001;
        tick();
        check("zl_release", 32'(busy), 32'h0);
        flit_fire = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
